vip_frame_ctrl: RTL and testbench
=================================

// Module: vip_frame_ctrl
// PURPOSE
//  Frame-synchronous controller for the Sobel video processing chain. Captures host
//  configuration (Sobel threshold, image mode) through a valid/ready handshake and
//  commits it only at a frame start, so the datapath never sees a mid-frame change.
//  Counts edge pixels on the processor output per frame and reports them at frame end.
//  Sits between the register/host side and the Video_Image_Processor config inputs.
// PARAMETERS
//  THRESH_INIT  8'd64     threshold driven after reset
//  MODE_INIT    4'd0      image mode driven after reset (0 = RGB888)
//  TARGET_LO    24'd2000  adaptive: edge count below this lowers the threshold
//  TARGET_HI    24'd20000 adaptive: edge count above this raises the threshold
//  STEP         8'd4      adaptive: threshold step per frame
// PORTS
//  clk               in   1   pixel clock
//  rst_n             in   1   asynchronous reset, active low
//  cfg_valid         in   1   host config valid
//  cfg_ready         out  1   controller can accept config
//  cfg_thresh        in   8   requested Sobel threshold
//  cfg_mode          in   4   requested image mode
//  auto_en           in   1   enable adaptive threshold (needs ADAPT_THRESH_EN)
//  per_frame_vsync   in   1   processor input vsync, high during frame
//  post_frame_vsync  in   1   processor output vsync
//  post_frame_href   in   1   processor output href
//  post_frame_clken  in   1   processor output pixel enable
//  post_img_Bit      in   1   processor output edge bit
//  Sobel_Threshold   out  8   active threshold to processor
//  per_img_mode      out  4   active image mode to processor
//  cfg_applied       out  1   1-cycle pulse when a new config is committed
//  edge_cnt          out  24  edge pixels in last complete frame
//  edge_cnt_valid    out  1   1-cycle pulse when edge_cnt updates
//  frame_cnt         out  16  completed output frames, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset: Sobel_Threshold=THRESH_INIT, per_img_mode=MODE_INIT, cfg_ready=1,
//    cfg_applied=0, edge_cnt=0, edge_cnt_valid=0, frame_cnt=0, FSM=IDLE, armed=0.
//  - Edge detect: vsync inputs registered once; rise = vs & ~vs_d; fall = ~vs & vs_d.
//  - FSM IDLE: cfg_ready=1; cfg_valid&cfg_ready loads shadow {thresh,mode} -> PEND.
//  - FSM PEND: cfg_ready=0; on per_frame_vsync rise, shadow -> active outputs at that
//    clock edge, cfg_applied=1 for that one cycle -> IDLE. Latency: outputs change the
//    edge after the rise is detected (2 clk after vsync goes high at the input).
//  - Config accepted in the rise cycle itself waits for the following frame start.
//  - Counter: armed set on post_frame_vsync rise; while armed, vsync high,
//    href & clken & Bit increments an internal 24-bit counter, saturating at 24'hFFFFFF.
//  - On post_frame_vsync fall with armed: edge_cnt <= counter, edge_cnt_valid=1 one
//    cycle, frame_cnt+1, counter cleared at the same edge. Fall without armed: no pulse.
//  - Reset mid-frame: all state cleared; the partial frame in flight is never reported.
//  - Pipeline delay through the processor is irrelevant: counting keys on post_* only.
// CONFIGURATION
//  ADAPT_THRESH_EN defined: on reported frame end with auto_en=1 and FSM IDLE, if
//    edge_cnt > TARGET_HI, shadow = min(255, thr + STEP); if < TARGET_LO,
//    shadow = max(0, thr - STEP); FSM -> PEND, commit at next frame start like host
//    config. Host transfer in the same cycle wins; adaptive update dropped. In PEND no
//    adaptive update. Counts within [TARGET_LO, TARGET_HI] do nothing.
//  ADAPT_THRESH_EN undefined: auto_en ignored, threshold changes only by host config.
// TESTING
//  1 Reset -> Sobel_Threshold=64, per_img_mode=0, cfg_ready=1, counts 0, no pulses.
//  2 cfg_thresh=0x30 mid-frame -> cfg_ready=0, threshold stays 64 until next vsync
//    rise, then 0x30 with one cfg_applied pulse, cfg_ready=1 next cycle.
//  3 4x4 frame, 5 pixels with Bit=1 and clken=1, 2 with Bit=1 and clken=0 ->
//    edge_cnt=5, edge_cnt_valid 1 cycle after the registered vsync fall, frame_cnt=1.
//  4 rst_n low during frame 2, released mid-frame -> no edge_cnt_valid for that frame;
//    the next full frame reports correctly, frame_cnt=1.
//  5 ADAPT_THRESH_EN on, auto_en=1, thr=64, 25000 edges -> 68 at next frame start;
//    thr=254 with STEP=4 -> 255; macro off -> stays 64.
//  6 Adaptive update and cfg_valid(thresh=0x10) in same cycle -> 0x10 committed,
//    one cfg_applied pulse.

Source files
------------

// File: rtl/vip_frame_ctrl_if.sv
// Host configuration handshake for vip_frame_ctrl.
//  cfg_valid   host -> ctrl   configuration word valid
//  cfg_ready   ctrl -> host   controller can accept a configuration word
//  cfg_thresh  host -> ctrl   requested Sobel threshold
//  cfg_mode    host -> ctrl   requested image mode
// master modport is the host side, slave modport is the controller side.
interface vip_frame_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_thresh;
    logic [3:0] cfg_mode;

    modport master (output cfg_valid, output cfg_thresh, output cfg_mode, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_thresh, input cfg_mode, output cfg_ready);
endinterface

// File: rtl/vip_frame_ctrl.sv
// vip_frame_ctrl: frame-synchronous configuration and edge statistics controller
// for the Sobel video processing chain.
//  - Host config {threshold, mode} is captured into a shadow register through the
//    cfg handshake and committed to Sobel_Threshold/per_img_mode only at the next
//    input frame start (per_frame_vsync rise), pulsing cfg_applied.
//  - Edge pixels on the processor output are counted per frame and reported at
//    the output frame end (edge_cnt/edge_cnt_valid, frame_cnt).
// Optional feature macro: ADAPT_THRESH_EN enables the adaptive threshold loop
// (auto_en steers the threshold by STEP toward [TARGET_LO, TARGET_HI]).
// Ports:
//  clk, rst_n                 clock, asynchronous active-low reset
//  cfg                        host handshake (vip_frame_ctrl_if.slave)
//  auto_en                    adaptive threshold enable
//  per_frame_vsync            processor input vsync
//  post_frame_*/post_img_Bit  processor output timing and edge bit
//  Sobel_Threshold/per_img_mode  active config to the processor
//  cfg_applied                one-cycle commit pulse
//  edge_cnt/edge_cnt_valid    last frame edge count and update pulse
//  frame_cnt                  completed output frames (wrapping)
//
// state | meaning
// IDLE  | no pending config, host may transfer
// PEND  | shadow config waiting for the next input frame start
module vip_frame_ctrl #(
    parameter logic [7:0]  THRESH_INIT = 8'd64,
    parameter logic [3:0]  MODE_INIT   = 4'd0,
    parameter logic [23:0] TARGET_LO   = 24'd2000,
    parameter logic [23:0] TARGET_HI   = 24'd20000,
    parameter logic [7:0]  STEP        = 8'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vip_frame_ctrl_if.slave       cfg,
    input  logic                  auto_en,
    input  logic                  per_frame_vsync,
    input  logic                  post_frame_vsync,
    input  logic                  post_frame_href,
    input  logic                  post_frame_clken,
    input  logic                  post_img_Bit,
    output logic [7:0]            Sobel_Threshold,
    output logic [3:0]            per_img_mode,
    output logic                  cfg_applied,
    output logic [23:0]           edge_cnt,
    output logic                  edge_cnt_valid,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [0:0] {S_IDLE, S_PEND} state_t;

    state_t      state, state_nxt;
    logic [7:0]  sh_thr, sh_thr_nxt;
    logic [3:0]  sh_mode, sh_mode_nxt;
    logic        commit;

    logic        pre_vs_q, pre_vs_d;
    logic        post_vs_q, post_vs_d;
    logic        href_q, clken_q, bit_q;
    logic        pre_rise, post_rise, post_fall;
    logic        armed;
    logic [23:0] cnt;
    logic        frame_done;

    // Vsync history resets high: if reset is released in the middle of a frame,
    // no rise is seen, so the partial frame is never armed and never reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_vs_q  <= 1'b1;
            pre_vs_d  <= 1'b1;
            post_vs_q <= 1'b1;
            post_vs_d <= 1'b1;
            href_q    <= 1'b0;
            clken_q   <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            pre_vs_q  <= per_frame_vsync;
            pre_vs_d  <= pre_vs_q;
            post_vs_q <= post_frame_vsync;
            post_vs_d <= post_vs_q;
            href_q    <= post_frame_href;
            clken_q   <= post_frame_clken;
            bit_q     <= post_img_Bit;
        end
    end

    assign pre_rise   = pre_vs_q & ~pre_vs_d;
    assign post_rise  = post_vs_q & ~post_vs_d;
    assign post_fall  = ~post_vs_q & post_vs_d;
    assign frame_done = post_fall & armed;

`ifdef ADAPT_THRESH_EN
    logic [8:0] thr_up;
    assign thr_up = {1'b0, Sobel_Threshold} + {1'b0, STEP};
`else
    logic [56:0] unused_adapt;
    assign unused_adapt = {auto_en, TARGET_LO, TARGET_HI, STEP};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sh_thr  <= THRESH_INIT;
            sh_mode <= MODE_INIT;
        end else begin
            state   <= state_nxt;
            sh_thr  <= sh_thr_nxt;
            sh_mode <= sh_mode_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sh_thr_nxt    = sh_thr;
        sh_mode_nxt   = sh_mode;
        commit        = 1'b0;
        cfg.cfg_ready = 1'b0;
        case (state)
            S_IDLE: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    // a host transfer always wins over an adaptive step
                    sh_thr_nxt  = cfg.cfg_thresh;
                    sh_mode_nxt = cfg.cfg_mode;
                    state_nxt   = S_PEND;
                end
`ifdef ADAPT_THRESH_EN
                else if (frame_done && auto_en) begin
                    if (cnt > TARGET_HI) begin
                        sh_thr_nxt  = thr_up[8] ? 8'hFF : thr_up[7:0];
                        sh_mode_nxt = per_img_mode;
                        state_nxt   = S_PEND;
                    end else if (cnt < TARGET_LO) begin
                        sh_thr_nxt  = (Sobel_Threshold < STEP) ? 8'h00 : Sobel_Threshold - STEP;
                        sh_mode_nxt = per_img_mode;
                        state_nxt   = S_PEND;
                    end
                end
`endif
            end
            S_PEND: begin
                if (pre_rise) begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sobel_Threshold <= THRESH_INIT;
            per_img_mode    <= MODE_INIT;
            cfg_applied     <= 1'b0;
        end else begin
            cfg_applied <= commit;
            if (commit) begin
                Sobel_Threshold <= sh_thr;
                per_img_mode    <= sh_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed          <= 1'b0;
            cnt            <= 24'd0;
            edge_cnt       <= 24'd0;
            edge_cnt_valid <= 1'b0;
            frame_cnt      <= 16'd0;
        end else if (frame_done) begin
            edge_cnt       <= cnt;
            edge_cnt_valid <= 1'b1;
            frame_cnt      <= frame_cnt + 16'd1;
            cnt            <= 24'd0;
            armed          <= 1'b0;
        end else begin
            edge_cnt_valid <= 1'b0;
            if (post_rise)
                armed <= 1'b1;
            if (armed && post_vs_q && href_q && clken_q && bit_q && (cnt != 24'hFFFFFF))
                cnt <= cnt + 24'd1;
        end
    end

endmodule

// File: tb/tb_vip_frame_ctrl.sv
module tb_vip_frame_ctrl;

`ifdef ADAPT_THRESH_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif
    localparam int TLO  = 2000;
    localparam int THI  = 20000;
    localparam int STP  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        auto_en;
    logic        per_frame_vsync, post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
    logic [7:0]  Sobel_Threshold;
    logic [3:0]  per_img_mode;
    logic        cfg_applied;
    logic [23:0] edge_cnt;
    logic        edge_cnt_valid;
    logic [15:0] frame_cnt;

    vip_frame_ctrl_if cfg_if ();

    vip_frame_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg              (cfg_if),
        .auto_en          (auto_en),
        .per_frame_vsync  (per_frame_vsync),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Bit     (post_img_Bit),
        .Sobel_Threshold  (Sobel_Threshold),
        .per_img_mode     (per_img_mode),
        .cfg_applied      (cfg_applied),
        .edge_cnt         (edge_cnt),
        .edge_cnt_valid   (edge_cnt_valid),
        .frame_cnt        (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: {thresh, mode} per commit, {edge_cnt, frame_cnt} per report
    logic [11:0] exp_cfg_q[$];
    logic [39:0] exp_edge_q[$];
    logic [11:0] mon_cfg;
    logic [39:0] mon_edge;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_applied) begin
                if (exp_cfg_q.size() == 0)
                    chk("cfg_applied_unexpected", 64'd1, 64'd0);
                else begin
                    mon_cfg = exp_cfg_q.pop_front();
                    chk("cfg_commit", {52'd0, Sobel_Threshold, per_img_mode}, {52'd0, mon_cfg});
                end
            end
            if (edge_cnt_valid) begin
                if (exp_edge_q.size() == 0)
                    chk("edge_valid_unexpected", 64'd1, 64'd0);
                else begin
                    mon_edge = exp_edge_q.pop_front();
                    chk("edge_report", {24'd0, edge_cnt, frame_cnt}, {24'd0, mon_edge});
                end
            end
        end
    end

    // reference model of the controller's visible state
    logic [7:0]  m_thr, m_sh_thr;
    logic [3:0]  m_mode, m_sh_mode;
    logic        m_pend;
    logic [15:0] m_frames;

    task automatic model_reset();
        m_thr = 8'd64; m_mode = 4'd0; m_pend = 1'b0;
        m_sh_thr = 8'd64; m_sh_mode = 4'd0; m_frames = 16'd0;
    endtask

    task automatic run_frame(input int lines, input int cols, input int n_edge, input int n_noclk,
                             input bit mid_en, input logic [7:0] mid_thr, input logic [3:0] mid_mode,
                             input bit fall_en, input logic [7:0] fall_thr, input logic [3:0] fall_mode);
        int pix;
        int exp_n;
        int up;
        logic [7:0] old_thr;
        logic [23:0] exp_c;
        @(negedge clk);
        per_frame_vsync  = 1'b1;
        post_frame_vsync = 1'b1;
        old_thr = m_thr;
        if (m_pend) begin
            exp_cfg_q.push_back({m_sh_thr, m_sh_mode});
            m_thr  = m_sh_thr;
            m_mode = m_sh_mode;
            m_pend = 1'b0;
        end
        exp_n = (n_edge < lines * cols) ? n_edge : lines * cols;
        exp_c = exp_n[23:0];
        m_frames = m_frames + 16'd1;
        exp_edge_q.push_back({exp_c, m_frames});
        @(negedge clk);
        chk("thr_before_commit", {56'd0, Sobel_Threshold}, {56'd0, old_thr});
        @(negedge clk);
        chk("thr_after_rise", {56'd0, Sobel_Threshold}, {56'd0, m_thr});
        chk("mode_after_rise", {60'd0, per_img_mode}, {60'd0, m_mode});
        chk("ready_after_rise", {63'd0, cfg_if.cfg_ready}, 64'd1);
        pix = 0;
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < cols; c++) begin
                post_frame_href  = 1'b1;
                post_frame_clken = !(pix >= n_edge && pix < n_edge + n_noclk);
                post_img_Bit     = (pix < n_edge + n_noclk);
                pix++;
                @(negedge clk);
            end
            post_frame_href = 1'b0; post_frame_clken = 1'b0; post_img_Bit = 1'b0;
            if (l == 0 && mid_en) begin
                cfg_if.cfg_valid  = 1'b1;
                cfg_if.cfg_thresh = mid_thr;
                cfg_if.cfg_mode   = mid_mode;
                @(negedge clk);
                cfg_if.cfg_valid = 1'b0;
                chk("ready_after_accept", {63'd0, cfg_if.cfg_ready}, 64'd0);
                chk("thr_hold_midframe", {56'd0, Sobel_Threshold}, {56'd0, m_thr});
                m_pend = 1'b1; m_sh_thr = mid_thr; m_sh_mode = mid_mode;
            end
            @(negedge clk);
            @(negedge clk);
        end
        per_frame_vsync  = 1'b0;
        post_frame_vsync = 1'b0;
        @(negedge clk);
        if (fall_en && !m_pend) begin
            cfg_if.cfg_valid  = 1'b1;
            cfg_if.cfg_thresh = fall_thr;
            cfg_if.cfg_mode   = fall_mode;
            m_pend = 1'b1; m_sh_thr = fall_thr; m_sh_mode = fall_mode;
        end else if (ADAPT && auto_en && !m_pend) begin
            if (exp_n > THI) begin
                up = int'(m_thr) + STP;
                m_sh_thr = (up > 255) ? 8'hFF : up[7:0];
                m_sh_mode = m_mode; m_pend = 1'b1;
            end else if (exp_n < TLO) begin
                m_sh_thr = (m_thr < STP) ? 8'h00 : m_thr - 8'(STP);
                m_sh_mode = m_mode; m_pend = 1'b1;
            end
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("edge_cnt_after_frame", {40'd0, edge_cnt}, {40'd0, exp_c});
        chk("frame_cnt_after_frame", {48'd0, frame_cnt}, {48'd0, m_frames});
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; auto_en = 1'b0;
        per_frame_vsync = 1'b0; post_frame_vsync = 1'b0;
        post_frame_href = 1'b0; post_frame_clken = 1'b0; post_img_Bit = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_thresh = 8'd0; cfg_if.cfg_mode = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_thresh", {56'd0, Sobel_Threshold}, 64'd64);
        chk("rst_mode", {60'd0, per_img_mode}, 64'd0);
        chk("rst_ready", {63'd0, cfg_if.cfg_ready}, 64'd1);
        chk("rst_applied", {63'd0, cfg_applied}, 64'd0);
        chk("rst_edge_cnt", {40'd0, edge_cnt}, 64'd0);
        chk("rst_edge_valid", {63'd0, edge_cnt_valid}, 64'd0);
        chk("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);

        // 4x4 frame: 5 counted edges, 2 edges without clken
        run_frame(4, 4, 5, 2, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        // mid-frame host config, committed at the following frame start
        run_frame(3, 4, 2, 0, 1'b1, 8'h30, 4'h2, 1'b0, 8'd0, 4'd0);
        run_frame(4, 4, 16, 0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);

        // reset in the middle of a frame, released mid-frame
        @(negedge clk);
        per_frame_vsync = 1'b1; post_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);
        post_frame_href = 1'b1; post_frame_clken = 1'b1; post_img_Bit = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        post_frame_href = 1'b0; post_frame_clken = 1'b0; post_img_Bit = 1'b0;
        @(negedge clk);
        per_frame_vsync = 1'b0; post_frame_vsync = 1'b0;
        repeat (4) @(negedge clk);
        chk("postrst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        chk("postrst_edge_cnt", {40'd0, edge_cnt}, 64'd0);
        chk("postrst_thresh", {56'd0, Sobel_Threshold}, 64'd64);
        run_frame(4, 4, 3, 1, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);

        // adaptive loop: low counts lower the threshold only with the feature built in
        auto_en = 1'b1;
        run_frame(2, 4, 0, 0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        run_frame(2, 4, 8, 0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        auto_en = 1'b0;
        if (ADAPT) begin
            run_frame(2, 4, 1, 0, 1'b1, 8'd64, 4'd0, 1'b0, 8'd0, 4'd0);
            auto_en = 1'b1;
            run_frame(100, 250, 25000, 0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
            auto_en = 1'b0;
            run_frame(2, 4, 1, 0, 1'b1, 8'd254, 4'd0, 1'b0, 8'd0, 4'd0);
            auto_en = 1'b1;
            run_frame(100, 250, 25000, 0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
            auto_en = 1'b0;
        end

        // host transfer in the frame-end cycle beats the adaptive update
        auto_en = 1'b1;
        run_frame(2, 4, 0, 0, 1'b0, 8'd0, 4'd0, 1'b1, 8'h10, 4'h1);
        auto_en = 1'b0;
        run_frame(2, 4, 4, 0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0);
        chk("final_thresh", {56'd0, Sobel_Threshold}, {56'd0, m_thr});

        repeat (5) @(negedge clk);
        chk("cfg_queue_drained", 64'(exp_cfg_q.size()), 64'd0);
        chk("edge_queue_drained", 64'(exp_edge_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
